huffman_bit_packer: RTL and testbench

//  Sits directly downstream of the Huffman encoding parser. Collects the serial

---
 rtl/huffman_bit_packer.sv | 147 ++++++++++++++
 tb/tb_huffman_bit_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer.sv
// Packs a strobed serial code bit stream into MSB-first words and queues them
// in a small FIFO toward a valid/ready sink, with message flush and error latch.
module huffman_bit_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_d,
    input  logic                          strobe,
    input  logic                          flush,
    input  logic                          dict_err,
    output logic [WORD_W-1:0]             out_data,
    output logic [$clog2(WORD_W+1)-1:0]   out_nbits,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          err,
    output logic                          busy
);
    localparam int CW = $clog2(WORD_W);
    localparam int NW = $clog2(WORD_W + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ACCUM, ERR} state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] acc_reg, acc_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              overflow_reg;

    logic [WORD_W-1:0] acc_shift;
    logic [WORD_W-1:0] fl_acc;
    logic [CW-1:0]     fl_cnt;
    logic [CW:0]       pad_amt;

    logic              push;
    logic [WORD_W-1:0] push_data;
    logic [NW-1:0]     push_nbits;
    logic              push_last;

    logic [WORD_W-1:0] mem_data  [FIFO_DEPTH];
    logic [NW-1:0]     mem_nbits [FIFO_DEPTH];
    logic              mem_last  [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic              fifo_empty, fifo_full, pop, push_ok;

    assign acc_shift = {acc_reg[WORD_W-2:0], serial_d};
    // Flush sees the accumulator after any same-cycle bit has been appended.
    assign fl_acc    = strobe ? acc_shift : acc_reg;
    assign fl_cnt    = strobe ? cnt_reg + CW'(1) : cnt_reg;
    assign pad_amt   = (CW+1)'(WORD_W) - {1'b0, fl_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        push       = 1'b0;
        push_data  = '0;
        push_nbits = '0;
        push_last  = 1'b0;
        case (state_reg)
            ACCUM: begin
                if (dict_err) begin
                    state_next = ERR;
                    acc_next   = '0;
                    cnt_next   = '0;
                end else if (strobe && cnt_reg == CW'(WORD_W-1)) begin
                    push       = 1'b1;
                    push_data  = acc_shift;
                    push_nbits = NW'(WORD_W);
                    push_last  = flush;
                    acc_next   = '0;
                    cnt_next   = '0;
                end else if (flush) begin
                    // Left-justify the partial word; an empty message yields all zeros.
                    push       = 1'b1;
                    push_data  = fl_acc << pad_amt;
                    push_nbits = NW'(fl_cnt);
                    push_last  = 1'b1;
                    acc_next   = '0;
                    cnt_next   = '0;
                end else if (strobe) begin
                    acc_next   = acc_shift;
                    cnt_next   = fl_cnt;
                end
            end
            ERR: begin
                acc_next = '0;
                cnt_next = '0;
            end
            default: state_next = ACCUM;
        endcase
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop        = out_valid && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr_reg[AW-1:0]]  <= push_data;
            mem_nbits[wr_ptr_reg[AW-1:0]] <= push_nbits;
            mem_last[wr_ptr_reg[AW-1:0]]  <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            if (push && !push_ok)
                overflow_reg <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? mem_data[rd_ptr_reg[AW-1:0]]  : '0;
    assign out_nbits = out_valid ? mem_nbits[rd_ptr_reg[AW-1:0]] : '0;
    assign out_last  = out_valid ? mem_last[rd_ptr_reg[AW-1:0]]  : 1'b0;
    assign overflow  = overflow_reg;
    assign err       = (state_reg == ERR);
    assign busy      = (cnt_reg != '0) || !fifo_empty;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: packing, flush, overflow, error latch.
module tb_huffman_bit_packer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_d = 1'b0;
    logic       strobe = 1'b0;
    logic       flush = 1'b0;
    logic       dict_err = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_nbits;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       overflow;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    huffman_bit_packer #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .serial_d(serial_d), .strobe(strobe),
        .flush(flush), .dict_err(dict_err), .out_data(out_data),
        .out_nbits(out_nbits), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        strobe   = 1'b1;
        serial_d = b;
        step();
        strobe   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    logic [7:0] t4_words [4];
    logic [7:0] w5c;

    initial begin
        // T1: reset held two cycles while strobing
        rst = 1'b1; strobe = 1'b1; serial_d = 1'b1;
        step(); step();
        check("t1_valid", 32'(out_valid), 0);
        check("t1_data", 32'(out_data), 0);
        check("t1_flags", {29'd0, overflow, err, busy}, 0);
        rst = 1'b0; strobe = 1'b0;
        step();
        check("t1_busy_after", 32'(busy), 0);

        // T2: one full word, sink ready
        out_ready = 1'b1;
        send_word(8'hB2);
        check("t2_valid", 32'(out_valid), 1);
        check("t2_data", 32'(out_data), 32'hB2);
        check("t2_nbits", 32'(out_nbits), 8);
        check("t2_last", 32'(out_last), 0);
        step();
        check("t2_drained", 32'(out_valid), 0);

        // T3: partial-word flush then empty-message flush
        out_ready = 1'b0;
        send_bit(1); send_bit(1); send_bit(1);
        check("t3_busy_partial", 32'(busy), 1);
        pulse_flush();
        check("t3_data", 32'(out_data), 32'hE0);
        check("t3_nbits", 32'(out_nbits), 3);
        check("t3_last", 32'(out_last), 1);
        pulse_flush();
        out_ready = 1'b1;
        step();
        check("t3_empty_valid", 32'(out_valid), 1);
        check("t3_empty_data", 32'(out_data), 0);
        check("t3_empty_nbits", 32'(out_nbits), 0);
        check("t3_empty_last", 32'(out_last), 1);
        step();
        check("t3_drained", 32'(out_valid), 0);

        // T4: overflow with five words into four entries
        out_ready = 1'b0;
        t4_words[0] = 8'hA1; t4_words[1] = 8'h5A; t4_words[2] = 8'hC3; t4_words[3] = 8'h0F;
        for (int i = 0; i < 4; i++) send_word(t4_words[i]);
        check("t4_no_ovf_yet", 32'(overflow), 0);
        send_word(8'h77);
        check("t4_overflow", 32'(overflow), 1);
        check("t4_head_stable", 32'(out_data), 32'hA1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_valid%0d", i), 32'(out_valid), 1);
            check($sformatf("t4_data%0d", i), 32'(out_data), 32'(t4_words[i]));
            step();
        end
        check("t4_drained", 32'(out_valid), 0);
        check("t4_ovf_sticky", 32'(overflow), 1);
        do_reset();
        check("t4_rst_clears_ovf", 32'(overflow), 0);

        // T5: eighth bit coincides with flush
        out_ready = 1'b0;
        w5c = 8'h5C;
        for (int i = 7; i >= 1; i--) send_bit(w5c[i]);
        strobe = 1'b1; serial_d = w5c[0]; flush = 1'b1;
        step();
        strobe = 1'b0; flush = 1'b0;
        check("t5_data", 32'(out_data), 32'h5C);
        check("t5_nbits", 32'(out_nbits), 8);
        check("t5_last", 32'(out_last), 1);
        out_ready = 1'b1;
        step();
        check("t5_no_extra", 32'(out_valid), 0);
        check("t5_busy", 32'(busy), 0);

        // T6: dictionary error with one word queued and a partial held
        out_ready = 1'b0;
        send_word(8'h3C);
        send_bit(1); send_bit(0); send_bit(1);
        dict_err = 1'b1;
        step();
        dict_err = 1'b0;
        check("t6_err", 32'(err), 1);
        send_word(8'hFF);
        pulse_flush();
        out_ready = 1'b1;
        check("t6_queued_valid", 32'(out_valid), 1);
        check("t6_queued_data", 32'(out_data), 32'h3C);
        step();
        check("t6_nothing_more", 32'(out_valid), 0);
        check("t6_busy_clear", 32'(busy), 0);
        check("t6_err_sticky", 32'(err), 1);
        do_reset();
        check("t6_rst_err", 32'(err), 0);
        check("t6_rst_ovf", 32'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
